// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register busy/tag scoreboard and
// same-cycle writeback bypass on both read ports.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned TAG_W    = 3,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  output logic [TAG_W-1:0]  rd_tag_1,
  output logic [TAG_W-1:0]  rd_tag_2,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [DATA_W-1:0]   data_d [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic wb_hit_1;
  logic wb_hit_2;

  // Next-state: writeback, then flush or allocate (allocate wins over wb clear)
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (wb_valid) begin
      data_d[wb_reg] = wb_data;
      if (busy_q[wb_reg] && (tag_q[wb_reg] == wb_tag)) begin
        busy_d[wb_reg] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (alloc_valid) begin
      busy_d[alloc_reg] = 1'b1;
      tag_d[alloc_reg]  = alloc_tag;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; a same-cycle writeback is forwarded
  always_comb begin
    wb_hit_1  = wb_valid && (wb_reg == rd_addr_1);
    wb_hit_2  = wb_valid && (wb_reg == rd_addr_2);
    rd_data_1 = wb_hit_1 ? wb_data : data_q[rd_addr_1];
    rd_data_2 = wb_hit_2 ? wb_data : data_q[rd_addr_2];
    rd_busy_1 = busy_q[rd_addr_1] && !(wb_hit_1 && (wb_tag == tag_q[rd_addr_1]));
    rd_busy_2 = busy_q[rd_addr_2] && !(wb_hit_2 && (wb_tag == tag_q[rd_addr_2]));
    rd_tag_1  = tag_q[rd_addr_1];
    rd_tag_2  = tag_q[rd_addr_2];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 8x4 instance plus a 16x8 instance.
module tb_regfile_scoreboard;

  logic clk;
  logic rst_n;
  logic [1:0] rd_addr_1, rd_addr_2;
  logic [7:0] rd_data_1, rd_data_2;
  logic       rd_busy_1, rd_busy_2;
  logic [2:0] rd_tag_1, rd_tag_2;
  logic       alloc_valid;
  logic [1:0] alloc_reg;
  logic [2:0] alloc_tag;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [2:0] wb_tag;
  logic [7:0] wb_data;
  logic       flush;

  logic        b_rst_n;
  logic [2:0]  b_rd_addr_1, b_rd_addr_2;
  logic [15:0] b_rd_data_1, b_rd_data_2;
  logic        b_rd_busy_1, b_rd_busy_2;
  logic [2:0]  b_rd_tag_1, b_rd_tag_2;
  logic        b_alloc_valid;
  logic [2:0]  b_alloc_reg;
  logic [2:0]  b_alloc_tag;
  logic        b_wb_valid;
  logic [2:0]  b_wb_reg;
  logic [2:0]  b_wb_tag;
  logic [15:0] b_wb_data;
  logic        b_flush;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .rd_tag_1(rd_tag_1), .rd_tag_2(rd_tag_2),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush)
  );

  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .TAG_W(3)) dut_wide (
    .clk(clk), .rst_n(b_rst_n),
    .rd_addr_1(b_rd_addr_1), .rd_addr_2(b_rd_addr_2),
    .rd_data_1(b_rd_data_1), .rd_data_2(b_rd_data_2),
    .rd_busy_1(b_rd_busy_1), .rd_busy_2(b_rd_busy_2),
    .rd_tag_1(b_rd_tag_1), .rd_tag_2(b_rd_tag_2),
    .alloc_valid(b_alloc_valid), .alloc_reg(b_alloc_reg), .alloc_tag(b_alloc_tag),
    .wb_valid(b_wb_valid), .wb_reg(b_wb_reg), .wb_tag(b_wb_tag), .wb_data(b_wb_data),
    .flush(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then changed away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_reg = 2'd0; alloc_tag = 3'd0;
    wb_valid = 1'b0; wb_reg = 2'd0; wb_tag = 3'd0; wb_data = 8'h00;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b_rst_n = 1'b0;
    idle_inputs();
    rd_addr_1 = 2'd0; rd_addr_2 = 2'd0;
    b_alloc_valid = 1'b0; b_alloc_reg = 3'd0; b_alloc_tag = 3'd0;
    b_wb_valid = 1'b0; b_wb_reg = 3'd0; b_wb_tag = 3'd0; b_wb_data = 16'h0;
    b_flush = 1'b0; b_rd_addr_1 = 3'd0; b_rd_addr_2 = 3'd0;
    tick(); tick();
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rd_addr_1 = 2'(r);
      rd_addr_2 = 2'(3 - r);
      #1;
      checks++;
      if ({rd_data_1, rd_busy_1, rd_tag_1, rd_data_2, rd_busy_2, rd_tag_2} !== 24'h0) begin
        errors++;
        $display("FAIL reset_read r%0d: got d1=%h b1=%b t1=%0d d2=%h b2=%b t2=%0d, want all 0",
                 r, rd_data_1, rd_busy_1, rd_tag_1, rd_data_2, rd_busy_2, rd_tag_2);
      end
    end
  endtask

  task automatic test_alloc_wb();
    tick();
    alloc_valid = 1'b1; alloc_reg = 2'd2; alloc_tag = 3'd5;
    tick();
    idle_inputs();
    rd_addr_1 = 2'd2; rd_addr_2 = 2'd2;
    #1;
    checks++;
    if (rd_busy_1 !== 1'b1 || rd_tag_1 !== 3'd5) begin
      errors++;
      $display("FAIL alloc_r2: got busy=%b tag=%0d, want busy=1 tag=5", rd_busy_1, rd_tag_1);
    end
    wb_valid = 1'b1; wb_reg = 2'd2; wb_tag = 3'd5; wb_data = 8'hA7;
    #1;
    checks++;
    if (rd_data_1 !== 8'hA7 || rd_busy_1 !== 1'b0 || rd_data_2 !== 8'hA7 || rd_busy_2 !== 1'b0) begin
      errors++;
      $display("FAIL wb_bypass_r2: got d1=%h b1=%b d2=%h b2=%b, want A7/0 on both",
               rd_data_1, rd_busy_1, rd_data_2, rd_busy_2);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_1 !== 8'hA7 || rd_busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL wb_commit_r2: got data=%h busy=%b, want A7/0", rd_data_1, rd_busy_1);
    end
  endtask

  task automatic test_tag_mismatch();
    alloc_valid = 1'b1; alloc_reg = 2'd1; alloc_tag = 3'd3;
    tick();
    alloc_tag = 3'd6;
    tick();
    idle_inputs();
    rd_addr_1 = 2'd1;
    wb_valid = 1'b1; wb_reg = 2'd1; wb_tag = 3'd3; wb_data = 8'h11;
    #1;
    checks++;
    if (rd_data_1 !== 8'h11 || rd_busy_1 !== 1'b1 || rd_tag_1 !== 3'd6) begin
      errors++;
      $display("FAIL stale_wb_bypass_r1: got d=%h b=%b t=%0d, want 11/1/6", rd_data_1, rd_busy_1, rd_tag_1);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (rd_data_1 !== 8'h11 || rd_busy_1 !== 1'b1 || rd_tag_1 !== 3'd6) begin
      errors++;
      $display("FAIL stale_wb_r1: got d=%h b=%b t=%0d, want 11/1/6", rd_data_1, rd_busy_1, rd_tag_1);
    end
    wb_valid = 1'b1; wb_reg = 2'd1; wb_tag = 3'd6; wb_data = 8'h22;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_1 !== 8'h22 || rd_busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL owner_wb_r1: got d=%h b=%b, want 22/0", rd_data_1, rd_busy_1);
    end
  endtask

  task automatic test_alloc_wb_same_cycle();
    rd_addr_1 = 2'd3;
    alloc_valid = 1'b1; alloc_reg = 2'd3; alloc_tag = 3'd4;
    wb_valid = 1'b1; wb_reg = 2'd3; wb_tag = 3'd0; wb_data = 8'h5C;
    #1;
    checks++;
    if (rd_data_1 !== 8'h5C || rd_busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_bypass_r3: got d=%h b=%b, want 5C/0", rd_data_1, rd_busy_1);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_1 !== 8'h5C || rd_busy_1 !== 1'b1 || rd_tag_1 !== 3'd4) begin
      errors++;
      $display("FAIL same_cycle_r3: got d=%h b=%b t=%0d, want 5C/1/4", rd_data_1, rd_busy_1, rd_tag_1);
    end
  endtask

  task automatic test_flush();
    alloc_valid = 1'b1; alloc_reg = 2'd0; alloc_tag = 3'd1;
    tick();
    alloc_reg = 2'd1; alloc_tag = 3'd2;
    tick();
    idle_inputs();
    rd_addr_1 = 2'd0; rd_addr_2 = 2'd1;
    #1;
    checks++;
    if (rd_busy_1 !== 1'b1 || rd_tag_1 !== 3'd1 || rd_busy_2 !== 1'b1 || rd_tag_2 !== 3'd2) begin
      errors++;
      $display("FAIL pre_flush: got b0=%b t0=%0d b1=%b t1=%0d, want 1/1 1/2",
               rd_busy_1, rd_tag_1, rd_busy_2, rd_tag_2);
    end
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_reg = 2'd2; alloc_tag = 3'd7;
    wb_valid = 1'b1; wb_reg = 2'd0; wb_tag = 3'd0; wb_data = 8'h33;
    tick();
    idle_inputs();
    for (int r = 0; r < 4; r++) begin
      rd_addr_1 = 2'(r);
      #1;
      checks++;
      if (rd_busy_1 !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy r%0d: got busy=%b, want 0", r, rd_busy_1);
      end
    end
    rd_addr_1 = 2'd0; rd_addr_2 = 2'd2;
    #1;
    checks++;
    if (rd_data_1 !== 8'h33 || rd_tag_2 !== 3'd5 || rd_data_2 !== 8'hA7) begin
      errors++;
      $display("FAIL flush_side: got r0 d=%h r2 t=%0d d=%h, want 33/5/A7", rd_data_1, rd_tag_2, rd_data_2);
    end
  endtask

  task automatic test_reset_midop();
    rst_n = 1'b0;
    alloc_valid = 1'b1; alloc_reg = 2'd1; alloc_tag = 3'd7;
    wb_valid = 1'b1; wb_reg = 2'd1; wb_tag = 3'd0; wb_data = 8'hFF;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    rd_addr_1 = 2'd1; rd_addr_2 = 2'd0;
    #1;
    checks++;
    if (rd_data_1 !== 8'h00 || rd_busy_1 !== 1'b0 || rd_tag_1 !== 3'd0 || rd_data_2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_midop: got r1 d=%h b=%b t=%0d r0 d=%h, want all 0",
               rd_data_1, rd_busy_1, rd_tag_1, rd_data_2);
    end
  endtask

  task automatic test_wide();
    b_wb_valid = 1'b1; b_wb_reg = 3'd7; b_wb_tag = 3'd0; b_wb_data = 16'hBEEF;
    b_alloc_valid = 1'b1; b_alloc_reg = 3'd5; b_alloc_tag = 3'd2;
    tick();
    b_wb_valid = 1'b0; b_alloc_valid = 1'b0;
    b_rd_addr_1 = 3'd7; b_rd_addr_2 = 3'd7;
    #1;
    checks++;
    if (b_rd_data_1 !== 16'hBEEF || b_rd_data_2 !== 16'hBEEF || b_rd_busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL wide_r7: got d1=%h d2=%h b=%b, want BEEF/BEEF/0", b_rd_data_1, b_rd_data_2, b_rd_busy_1);
    end
    b_rd_addr_2 = 3'd5;
    #1;
    checks++;
    if (b_rd_busy_2 !== 1'b1 || b_rd_tag_2 !== 3'd2) begin
      errors++;
      $display("FAIL wide_alloc_r5: got b=%b t=%0d, want 1/2", b_rd_busy_2, b_rd_tag_2);
    end
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      b_rd_addr_1 = 3'(r);
      b_rd_addr_2 = 3'(7 - r);
      #1;
      checks++;
      if (b_rd_data_1 !== 16'h0 || b_rd_data_2 !== 16'h0 || b_rd_busy_1 !== 1'b0 || b_rd_busy_2 !== 1'b0) begin
        errors++;
        $display("FAIL wide_reset r%0d: got d1=%h d2=%h b1=%b b2=%b, want 0",
                 r, b_rd_data_1, b_rd_data_2, b_rd_busy_1, b_rd_busy_2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc_wb();
    test_tag_mismatch();
    test_alloc_wb_same_cycle();
    test_flush();
    test_reset_midop();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
